// File: rtl/marker_overlay.sv
// marker_overlay: draws a cross marker at latched centroid coordinates on an RGB video stream, 2-cycle latency.
// Ports: clk/rst_n (async active-low); de/hsync/vsync_in + pixel_in (24b RGB) in;
// x_in/y_in (12b, 1-based centroid); de/hsync/vsync_out + pixel_out delayed 2 cycles; mark_active (latched coords valid).
module marker_overlay #(
  parameter int          IMG_W      = 64,
  parameter int          IMG_H      = 64,
  parameter int          MARK_HALF  = 3,
  parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] pixel_in,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out,
  output logic        mark_active
);
  localparam logic [11:0] W12 = 12'(IMG_W);
  localparam logic [11:0] H12 = 12'(IMG_H);
  localparam logic signed [12:0] HALF = 13'(MARK_HALF);
  logic de_d, vs_d, de_fall, vs_rise, coord_ok, hit;
  logic [11:0] col, row, cx, cy;
  logic signed [12:0] dc, dr;
  logic de1, hs1, vs1, hit1;
  logic [23:0] pix1;
  assign de_fall  = de_d & ~de_in;
  assign vs_rise  = vsync_in & ~vs_d;
  assign coord_ok = x_in != 12'd0 && x_in <= W12 && y_in != 12'd0 && y_in <= H12;
  // Zero-extended signed differences so a marker near an edge clips instead of wrapping.
  assign dc  = $signed({1'b0, col}) - $signed({1'b0, cx});
  assign dr  = $signed({1'b0, row}) - $signed({1'b0, cy});
  // Uses the currently latched cx/cy, so a pixel coinciding with the vsync edge still sees the old marker.
  assign hit = mark_active && ((col == cx && dr <= HALF && dr >= -HALF) ||
                               (row == cy && dc <= HALF && dc >= -HALF));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d        <= 1'b0;
      vs_d        <= 1'b0;
      col         <= 12'd1;
      row         <= 12'd1;
      cx          <= '0;
      cy          <= '0;
      mark_active <= 1'b0;
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      hit1        <= 1'b0;
      pix1        <= '0;
      de_out      <= 1'b0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      pixel_out   <= '0;
    end else begin
      de_d <= de_in;
      vs_d <= vsync_in;
      // Counters saturate at 4095 so oversized timing never wraps back onto the marker.
      if (de_in) col <= col + 12'(col != 12'hFFF);
      else if (de_fall) col <= 12'd1;
      if (vs_rise) row <= 12'd1;
      else if (de_fall) row <= row + 12'(row != 12'hFFF);
      if (vs_rise) begin
        cx          <= x_in;
        cy          <= y_in;
        mark_active <= coord_ok;
      end
      de1       <= de_in;
      hs1       <= hsync_in;
      vs1       <= vsync_in;
      pix1      <= pixel_in;
      hit1      <= hit;
      de_out    <= de1;
      hsync_out <= hs1;
      vsync_out <= vs1;
      pixel_out <= de1 ? (hit1 ? MARK_COLOR : pix1) : 24'h000000;
    end
  end
endmodule

// File: tb/tb_marker_overlay.sv
// tb_marker_overlay: frame-level model of the cross marker checked against marker_overlay every cycle.
module tb_marker_overlay;
  localparam int W = 64;
  localparam int H = 64;
  localparam int MH = 3;
  localparam logic [23:0] MC = 24'hFF0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic de_in, hsync_in, vsync_in, de_out, hsync_out, vsync_out, mark_active;
  logic [23:0] pixel_in, pixel_out;
  logic [11:0] x_in, y_in;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic [23:0] pix;
  } exp_t;
  exp_t q[$];
  exp_t got;
  int tests = 0;
  int fails = 0;
  int dut_cnt = 0;
  int mcnt = 0;
  int mx = 0;
  int my = 0;
  bit mact = 0;
  bit last_vs = 0;
  bit rel_pending = 0;
  always #5 clk = ~clk;
  marker_overlay #(.IMG_W(W), .IMG_H(H), .MARK_HALF(MH), .MARK_COLOR(MC)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_in(pixel_in), .x_in(x_in), .y_in(y_in), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .pixel_out(pixel_out), .mark_active(mark_active)
  );
  function automatic bit is_mark(int c, int r);
    return mact && ((c == mx && r - my <= MH && my - r <= MH) ||
                    (r == my && c - mx <= MH && mx - c <= MH));
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic step(input logic de, input logic hs, input logic vs, input int c, input int r);
    logic [23:0] pix;
    exp_t e;
    @(posedge clk);
    #1;
    if (rel_pending) begin
      rst_n = 1'b1;
      rel_pending = 0;
    end
    pix = 24'($urandom);
    if (pix == MC) pix = pix ^ 24'h1;
    de_in = de;
    hsync_in = hs;
    vsync_in = vs;
    pixel_in = pix;
    if (rst_n) begin
      e.de = de;
      e.hs = hs;
      e.vs = vs;
      e.pix = !de ? 24'h0 : (is_mark(c, r) ? MC : pix);
      if (de && is_mark(c, r)) mcnt++;
      q.push_back(e);
      if (vs && !last_vs) begin
        mx = int'(x_in);
        my = int'(y_in);
        mact = x_in >= 1 && x_in <= W && y_in >= 1 && y_in <= H;
      end
      last_vs = vs;
    end
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    mact = 0;
    last_vs = 0;
    repeat (2) step(0, 0, 0, 0, 0);
    rel_pending = 1;
  endtask
  task automatic frame(input int x, input int y, input int x2, input int chg_row,
                       input int rst_row, input int exp_marks, input logic exp_act);
    int d0, m0;
    d0 = dut_cnt;
    m0 = mcnt;
    x_in = 12'(x);
    y_in = 12'(y);
    repeat (3) step(0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    for (int r = 1; r <= H; r++) begin
      if (r == chg_row) x_in = 12'(x2);
      if (r == rst_row) pulse_reset();
      repeat (3) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int c = 1; c <= W; c++) step(1, 0, 0, c, r);
    end
    repeat (3) step(0, 0, 0, 0, 0);
    check("marks_model", 32'(mcnt - m0), 32'(exp_marks));
    check("marks_dut", 32'(dut_cnt - d0), 32'(exp_marks));
    check("mark_active", {31'b0, mark_active}, {31'b0, exp_act});
  endtask
  always @(negedge clk) begin
    if (!rst_n) check("reset_out", {4'b0, de_out, hsync_out, vsync_out, mark_active, pixel_out}, 32'h0);
    else begin
      if (de_out && pixel_out == MC) dut_cnt++;
      if (q.size() == 3) begin
        got = q.pop_front();
        check("stream", {5'b0, de_out, hsync_out, vsync_out, pixel_out}, {5'b0, got});
      end
    end
  end
  initial begin
    de_in = 0;
    hsync_in = 0;
    vsync_in = 0;
    pixel_in = '0;
    x_in = '0;
    y_in = '0;
    @(negedge clk);
    check("reset_state", {4'b0, de_out, hsync_out, vsync_out, mark_active, pixel_out}, 32'h0);
    rel_pending = 1;
    frame(32, 20, 32, 0, 0, 13, 1'b1);
    frame(1, 1, 1, 0, 0, 7, 1'b1);
    frame(0, 0, 0, 0, 0, 0, 1'b0);
    frame(32, 0, 32, 0, 0, 0, 1'b0);
    frame(65, 20, 65, 0, 0, 0, 1'b0);
    frame(10, 20, 50, 30, 0, 13, 1'b1);
    frame(50, 20, 50, 0, 0, 13, 1'b1);
    frame(32, 40, 32, 0, 30, 0, 1'b0);
    frame(32, 40, 32, 0, 0, 13, 1'b1);
    x_in = '0;
    y_in = '0;
    repeat (2) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0), 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    check("random_mark_active", {31'b0, mark_active}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
